// File: rtl/capture_pkg.sv
// Shared definitions for the capture FIFO and the DiscReader datapath:
// default sizes, the operation encoding and a constant-safe clog2.
package capture_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 8;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_WRITE,
      OP_READ,
      OP_BOTH
   } fifo_op_e;

   // Smallest n with 2**n >= value; usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// One-register rising-edge detector; a strobe held high yields a single pulse.
module strobe_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic strobe,
   output logic rise
);

   logic strobe_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= strobe;
      end
   end

   assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/capture_fifo.sv
// Edge-triggered capture FIFO: one word stored per rising wr_strobe,
// one word returned per cycle of rd_req, with sticky overflow/underflow flags.
module capture_fifo
   import capture_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int DEPTH      = DEFAULT_DEPTH,
   localparam int ADDR_WIDTH = clog2(DEPTH),
   localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_strobe,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_req,
   input  logic                  flag_clr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   logic                  wr_edge;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_fire;
   logic                  wr_fire;
   logic                  overflow_event;
   logic                  underflow_event;
   fifo_op_e              op;
   logic [CNT_WIDTH-1:0]  count_next;

   strobe_edge_detect u_wr_edge (
      .clock  (clock),
      .reset  (reset),
      .strobe (wr_strobe),
      .rise   (wr_edge)
   );

   // Explicit wrap so non-power-of-two depths use exactly DEPTH slots.
   function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
      return (ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
   endfunction

   // A write while full is still accepted when a read frees a slot this cycle.
   always_comb begin
      rd_fire         = rd_req && !empty;
      wr_fire         = wr_edge && (!full || rd_fire);
      overflow_event  = wr_edge && full && !rd_fire;
      underflow_event = rd_req && empty;

      op = OP_NONE;
      if (wr_fire && rd_fire) begin
         op = OP_BOTH;
      end else if (wr_fire) begin
         op = OP_WRITE;
      end else if (rd_fire) begin
         op = OP_READ;
      end

      count_next = count;
      unique case (op)
         OP_WRITE: count_next = count + CNT_WIDTH'(1);
         OP_READ:  count_next = count - CNT_WIDTH'(1);
         default:  count_next = count;
      endcase
   end

   // Storage carries no reset so it can map onto block RAM.
   always_ff @(posedge clock) begin
      if (wr_fire && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (rd_fire) begin
            rd_ptr  <= next_ptr(rd_ptr);
            rd_data <= mem[rd_ptr];
         end
         rd_valid  <= rd_fire;
         count     <= count_next;
         empty     <= (count_next == '0);
         full      <= (count_next == CNT_WIDTH'(DEPTH));
         // A new event wins over a simultaneous flag_clr.
         overflow  <= overflow_event  | (overflow  & ~flag_clr);
         underflow <= underflow_event | (underflow & ~flag_clr);
      end
   end

endmodule

// File: tb/tb_capture_fifo.sv
// Self-checking bench for capture_fifo: a DEPTH=8 instance driven from a vector
// table plus hand sequences, and a DEPTH=5 instance exercising pointer wrap.
module tb_capture_fifo;

   logic       clock;
   logic       reset;

   logic       flush, wr_strobe, rd_req, flag_clr;
   logic [7:0] wr_data, rd_data;
   logic       rd_valid, empty, full, overflow, underflow;
   logic [3:0] count;

   logic       flush5, wr_strobe5, rd_req5, flag_clr5;
   logic [7:0] wr_data5, rd_data5;
   logic       rd_valid5, empty5, full5, overflow5, underflow5;
   logic [2:0] count5;

   typedef struct {
      logic       strobe;
      logic [7:0] data;
      logic       rd;
      logic       fl;
      logic       clr;
      logic       push;
      int         exp_count;
      logic       exp_ovf;
      logic       exp_unf;
      logic       exp_valid;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   logic [7:0] sb5[$];
   int         checks;
   int         errors;

   capture_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .wr_strobe (wr_strobe),
      .wr_data   (wr_data),
      .rd_req    (rd_req),
      .flag_clr  (flag_clr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   capture_fifo #(.DATA_WIDTH(8), .DEPTH(5)) dut5 (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush5),
      .wr_strobe (wr_strobe5),
      .wr_data   (wr_data5),
      .rd_req    (rd_req5),
      .flag_clr  (flag_clr5),
      .rd_data   (rd_data5),
      .rd_valid  (rd_valid5),
      .count     (count5),
      .empty     (empty5),
      .full      (full5),
      .overflow  (overflow5),
      .underflow (underflow5)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic s, input logic [7:0] d, input logic r,
                               input logic fl, input logic clr, input logic push,
                               input int c, input logic ovf, input logic unf, input logic v);
      vec_t t;
      t.strobe    = s;
      t.data      = d;
      t.rd        = r;
      t.fl        = fl;
      t.clr       = clr;
      t.push      = push;
      t.exp_count = c;
      t.exp_ovf   = ovf;
      t.exp_unf   = unf;
      t.exp_valid = v;
      vecs.push_back(t);
   endfunction

   task automatic applyStimulus(input vec_t v);
      wr_strobe = v.strobe;
      wr_data   = v.data;
      rd_req    = v.rd;
      flush     = v.fl;
      flag_clr  = v.clr;
      if (v.push) sb.push_back(v.data);
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      check({tag, "_count"},     count,     v.exp_count);
      check({tag, "_empty"},     empty,     v.exp_count == 0);
      check({tag, "_full"},      full,      v.exp_count == 8);
      check({tag, "_overflow"},  overflow,  v.exp_ovf);
      check({tag, "_underflow"}, underflow, v.exp_unf);
      check({tag, "_rd_valid"},  rd_valid,  v.exp_valid);
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_unexpected_data actual=%0h expected=none", tag, rd_data);
         end else begin
            check({tag, "_rd_data"}, rd_data, sb.pop_front());
         end
      end
   endtask

   task automatic applyStimulus5(input logic s, input logic [7:0] d, input logic r,
                                 input logic push, input int exp_count);
      string tag;
      wr_strobe5 = s;
      wr_data5   = d;
      rd_req5    = r;
      if (push) sb5.push_back(d);
      @(posedge clock);
      #1;
      tag = $sformatf("wrap_c%0d", exp_count);
      check({tag, "_count"},    count5,    exp_count);
      check({tag, "_full"},     full5,     exp_count == 5);
      check({tag, "_empty"},    empty5,    exp_count == 0);
      check({tag, "_overflow"}, overflow5, 0);
      if (rd_valid5 === 1'b1) begin
         if (sb5.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wrap_unexpected_data actual=%0h expected=none", rd_data5);
         end else begin
            check({tag, "_rd_data"}, rd_data5, sb5.pop_front());
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      flush      = 1'b0; wr_strobe  = 1'b0; rd_req  = 1'b0; flag_clr  = 1'b0; wr_data  = '0;
      flush5     = 1'b0; wr_strobe5 = 1'b0; rd_req5 = 1'b0; flag_clr5 = 1'b0; wr_data5 = '0;

      repeat (2) @(posedge clock);
      #1;
      check("rst_count",     count,     0);
      check("rst_empty",     empty,     1);
      check("rst_full",      full,      0);
      check("rst_overflow",  overflow,  0);
      check("rst_underflow", underflow, 0);
      check("rst_rd_valid",  rd_valid,  0);
      check("rst_rd_data",   rd_data,   0);
      reset = 1'b0;

      for (int i = 0; i < 2; i++) begin
         wr_strobe = 1'b1;
         wr_data   = 8'h50 + 8'(i);
         @(posedge clock); #1;
         wr_strobe = 1'b0;
         @(posedge clock); #1;
      end
      check("pre_reset_count", count, 2);

      // Reset mid-write with a read request pending, between clock edges.
      wr_strobe = 1'b1;
      wr_data   = 8'h77;
      rd_req    = 1'b1;
      #2 reset  = 1'b1;
      #1;
      check("async_count",     count,     0);
      check("async_empty",     empty,     1);
      check("async_overflow",  overflow,  0);
      check("async_underflow", underflow, 0);
      check("async_rd_valid",  rd_valid,  0);
      rd_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         check("reset_hold_valid", rd_valid, 0);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      check("release_edge_count", count,    1);
      check("release_valid",      rd_valid, 0);
      wr_strobe = 1'b0;

      // Vector table: s, data, rd, flush, clr, push, count, ovf, unf, valid
      add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         add(1, 8'(i), 0, 0, 0, 1, i, 0, 0, 0);
         add(0, 8'h00, 0, 0, 0, 0, i, 0, 0, 0);
      end
      add(1, 8'h09, 0, 0, 0, 0, 8, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 8, 1, 0, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         add(0, 8'h00, 1, 0, 0, 0, 8 - i, 0, 0, 1);
      end
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 0);
      add(1, 8'h33, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 8'hA5, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         add(1, 8'hA5, 0, 0, 0, 0, 1, 0, 0, 0);
      end
      add(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1);
      add(1, 8'h10, 0, 0, 0, 1, 1, 0, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 8'h11, 1, 0, 0, 1, 1, 0, 0, 1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1);
      add(1, 8'h22, 1, 0, 0, 1, 1, 0, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
      end
      wr_strobe = 1'b0; rd_req = 1'b0; flush = 1'b0; flag_clr = 1'b0;
      check("sb_drained", sb.size(), 0);

      // DEPTH=5: fill, then write-at-full with a read each time to force wrap.
      for (int k = 0; k < 5; k++) begin
         applyStimulus5(1, 8'h40 + 8'(k), 0, 1, k + 1);
         applyStimulus5(0, 8'h00, 0, 0, k + 1);
      end
      for (int k = 5; k < 12; k++) begin
         applyStimulus5(1, 8'h40 + 8'(k), 1, 1, 5);
         applyStimulus5(0, 8'h00, 0, 0, 5);
      end
      for (int k = 4; k >= 0; k--) begin
         applyStimulus5(0, 8'h00, 1, 0, k);
      end
      rd_req5 = 1'b0;
      @(posedge clock); #1;
      check("wrap_sb_drained", sb5.size(), 0);
      check("wrap_no_extra_valid", rd_valid5, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
